output_drain_serializer: RTL

- Sits directly downstream of the systolic array's top-level control and datapath.
- When the controller raises finish, this block captures the full Dimension-lane result vector (output_out) in one cycle.
- It then streams the lanes out one word per beat over a valid/ready interface toward the DMA/AXI-stream writer.
- It can optionally apply ReLU per word and flags captures that are dropped because the block is still busy.

---
 rtl/output_drain_serializer.sv | 98 +++++++++
 1 files changed

// File: rtl/output_drain_serializer.sv
// Captures a Dimension-lane result vector in one cycle and drains it one word per
// valid/ready beat, with optional per-word ReLU and a sticky flag for dropped captures.
//
// state  | meaning
// IDLE   | no burst in flight; any capture is accepted
// STREAM | draining lane_buf_q[cnt_q]; m_valid held high until the last handshake
module output_drain_serializer #(
  parameter int DW        = 16,
  parameter int Dimension = 16,
  parameter int IW        = $clog2(Dimension)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        capture,
  input  logic                        relu_en,
  input  logic [DW*Dimension-1:0]     psum_in,
  output logic                        capture_ready,
  output logic signed [DW-1:0]        m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        m_last,
  output logic [IW-1:0]               m_index,
  output logic                        busy,
  output logic                        drop_err,
  input  logic                        err_clr
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                state_q, state_d;
  logic signed [DW-1:0]  lane_buf_q [Dimension];
  logic signed [DW-1:0]  lane_buf_d [Dimension];
  logic [IW-1:0]         cnt_q, cnt_d;
  logic                  relu_q, relu_d;
  logic                  drop_err_q, drop_err_d;

  logic                  xfer;
  logic                  at_last;
  logic                  accept;
  logic signed [DW-1:0]  word;

  assign m_valid       = (state_q == STREAM);
  assign busy          = (state_q == STREAM);
  assign at_last       = (cnt_q == IW'(Dimension - 1));
  assign m_last        = m_valid & at_last;
  assign xfer          = m_valid & m_ready;
  // A capture landing on the final handshake starts the next burst with no gap.
  assign capture_ready = (state_q == IDLE) | (xfer & at_last);
  assign accept        = capture & capture_ready;

  assign word     = lane_buf_q[cnt_q];
  assign m_data   = (relu_q && word[DW-1]) ? '0 : word;
  assign m_index  = cnt_q;
  assign drop_err = drop_err_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    relu_d     = relu_q;
    drop_err_d = drop_err_q;
    for (int i = 0; i < Dimension; i++) lane_buf_d[i] = lane_buf_q[i];

    if (accept) begin
      state_d = STREAM;
      cnt_d   = '0;
      relu_d  = relu_en;
      for (int i = 0; i < Dimension; i++) lane_buf_d[i] = psum_in[DW*i +: DW];
    end else if (xfer) begin
      if (at_last) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // A new drop outranks a simultaneous clear.
    if (capture && !capture_ready) drop_err_d = 1'b1;
    else if (err_clr)              drop_err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      relu_q     <= 1'b0;
      drop_err_q <= 1'b0;
      for (int i = 0; i < Dimension; i++) lane_buf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      relu_q     <= relu_d;
      drop_err_q <= drop_err_d;
      for (int i = 0; i < Dimension; i++) lane_buf_q[i] <= lane_buf_d[i];
    end
  end

endmodule
